// File: rtl/bcd_cnt_pkg.sv
// Shared BCD digit type, digit limits and load-value clamp for the BCD up/down counter.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any nibble above 9 is not a decimal digit; it is pinned to the largest legal one.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter: synchronous load, or one step when carry-in is high.
// co is combinational so the carry/borrow ripples through every digit within one cycle.
module bcd_digit
  import bcd_cnt_pkg::*;
#(
  parameter bcd_digit_t RST_VAL = BCD_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ci,
  input  logic       up,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t q,
  output logic       co
);

  bcd_digit_t r_q;
  bcd_digit_t w_next;

  assign co = ci & (up ? (r_q == BCD_MAX) : (r_q == BCD_MIN));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_q;
    if (up) w_next = (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
    else    w_next = (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_q <= RST_VAL;
    else if (ld) r_q <= bcd_clamp(ld_val);
    else if (ci) r_q <= w_next;
  end

  assign q = r_q;

endmodule

// File: rtl/bcd_updn_cnt.sv
// Cascaded DIGITS-digit BCD up/down counter with load, terminal-count and load-error pulses.
// Define BCD_UPDN_CNT_SAT_EN for saturating mode; otherwise the count wraps at its limits.
module bcd_updn_cnt
  import bcd_cnt_pkg::*;
#(
  parameter int         DIGITS    = 4,
  parameter bcd_digit_t RST_DIGIT = 4'd9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  tc,
  output logic                  load_err,
  output logic                  zero
);

  logic [DIGITS:0]   w_ci;
  logic [DIGITS-1:0] w_bad;
  logic              w_tc_next;
  logic              r_tc;
  logic              r_load_err;

`ifdef BCD_UPDN_CNT_SAT_EN
  logic [DIGITS-1:0] w_at_lim;
  logic              w_blocked;

  // Every digit sitting at the limit in the current direction means the step would wrap.
  assign w_blocked = &w_at_lim;
  assign w_ci[0]   = en & ~load & ~w_blocked;
  assign w_tc_next = en & ~load & w_blocked;
`else
  assign w_ci[0]   = en & ~load;
  assign w_tc_next = w_ci[DIGITS];
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_bad[g] = load_val[4*g +: 4] > BCD_MAX;

`ifdef BCD_UPDN_CNT_SAT_EN
    assign w_at_lim[g] = cnt[4*g +: 4] == (up ? BCD_MAX : BCD_MIN);
`endif

    bcd_digit #(
      .RST_VAL (RST_DIGIT)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .ci     (w_ci[g]),
      .up     (up),
      .ld     (load),
      .ld_val (load_val[4*g +: 4]),
      .q      (cnt[4*g +: 4]),
      .co     (w_ci[g+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_tc       <= w_tc_next;
      r_load_err <= load & (|w_bad);
    end
  end

  assign tc       = r_tc;
  assign load_err = r_load_err;
  assign zero     = (cnt == '0);

endmodule
